// File: rtl/riscv_fetch_buffer_pkg.sv
// Types and helpers shared by the fetch buffer and its storage FIFO.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN 32
`define RISCV_NOP 32'h0000_0013
`endif

package riscv_fetch_buffer_pkg;

    localparam int XLEN = `XLEN;
    localparam logic [XLEN-1:0] NOP = `RISCV_NOP;

    // Instruction in the upper half so a {word, pc} concatenation packs directly.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_configs.v
// Core-wide constants shared by the RV32I pipeline blocks.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN 32
`define RISCV_NOP 32'h0000_0013
`endif

// File: rtl/riscv_fetch_fifo.sv
// Circular DEPTH-entry store of fetched {instruction, pc} pairs with level
// tracking and a synchronous clear used for redirect flushes.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN 32
`define RISCV_NOP 32'h0000_0013
`endif

module riscv_fetch_fifo
    import riscv_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  fetch_entry_t               wdata_i,
    input  logic                       pop_i,
    output fetch_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          empty, full;
    logic          push_ok, pop_ok;
    fetch_entry_t  mem_q [DEPTH];

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        if (clr_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + AW'(1);
            if (pop_ok)  rptr_d = rptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: level gates every read that matters.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/riscv_fetch_buffer.sv
// Instruction prefetch queue between synchronous imem and decode.
// Optional same-cycle forwarding when empty: define RISCV_FETCH_BYPASS_EN.
`ifndef RISCV_CONFIGS_V
`define RISCV_CONFIGS_V
`define XLEN 32
`define RISCV_NOP 32'h0000_0013
`endif

module riscv_fetch_buffer
    import riscv_fetch_buffer_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [`XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    output logic [`XLEN-1:0]        o_im_addr,
    output logic                    o_im_req,
    input  logic [`XLEN-1:0]        i_im_rd,
    output logic                    o_instr_valid,
    output logic [`XLEN-1:0]        o_instr,
    output logic [`XLEN-1:0]        o_pc,
    output logic [`XLEN-1:0]        o_pc_plus4,
    input  logic                    i_stall_d,
    input  logic                    i_redirect,
    input  logic [`XLEN-1:0]        i_redirect_pc,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] last_pc_q, last_pc_d;
    logic            inflight_q, inflight_d;
    logic            killed_q, killed_d;

    logic [LW-1:0]   level;
    logic [LW-1:0]   occupancy;
    logic            im_req;
    logic            resp_ok;
    logic            head_valid;
    logic            bypass;
    logic            out_valid;
    logic            pop;
    logic            fifo_pop;
    logic            push;
    fetch_entry_t    head;
    fetch_entry_t    out_entry;

    // Credit counts the slot reserved by an outstanding response.
    assign occupancy = level + LW'(inflight_q);
    assign im_req    = i_rstn && (occupancy < LW'(DEPTH));
    assign resp_ok   = inflight_q && !killed_q;
    assign head_valid = (level != '0);

`ifdef RISCV_FETCH_BYPASS_EN
    assign bypass    = !head_valid && resp_ok;
    assign out_entry = head_valid ? head : {i_im_rd, resp_pc_q};
`else
    assign bypass    = 1'b0;
    assign out_entry = head;
`endif

    assign out_valid = head_valid || bypass;
    assign pop       = out_valid && !i_stall_d && !i_redirect;
    assign fifo_pop  = pop && head_valid;
    // A forwarded word that decode takes is never stored.
    assign push      = resp_ok && !i_redirect && !(bypass && pop);

    riscv_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rstn),
        .clr_i   (i_redirect),
        .push_i  (push),
        .wdata_i ({i_im_rd, resp_pc_q}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .level_o (level)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = im_req;
        killed_d   = i_redirect;
        last_pc_d  = o_pc;
        if (i_redirect) begin
            fetch_pc_d = word_align(i_redirect_pc);
        end else if (im_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (im_req) begin
            resp_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            last_pc_q  <= '0;
            inflight_q <= 1'b0;
            killed_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            last_pc_q  <= last_pc_d;
            inflight_q <= inflight_d;
            killed_q   <= killed_d;
        end
    end

    assign o_im_addr     = fetch_pc_q;
    assign o_im_req      = im_req;
    assign o_instr_valid = out_valid;
    assign o_instr       = out_valid ? out_entry.instr : NOP;
    // When empty the PC output keeps showing whatever decode last saw.
    assign o_pc          = out_valid ? out_entry.pc : last_pc_q;
    assign o_pc_plus4    = o_pc + XLEN'(4);
    assign o_level       = level;

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Self-checking bench for riscv_fetch_buffer with a behavioural imem and a
// PC-ordered scoreboard of expected decode-side instructions.
module tb_riscv_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam int          LW       = $clog2(DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef RISCV_FETCH_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic          clk;
    logic          i_rstn;
    logic [31:0]   o_im_addr;
    logic          o_im_req;
    logic [31:0]   i_im_rd;
    logic          o_instr_valid;
    logic [31:0]   o_instr;
    logic [31:0]   o_pc;
    logic [31:0]   o_pc_plus4;
    logic          i_stall_d;
    logic          i_redirect;
    logic [31:0]   i_redirect_pc;
    logic [LW-1:0] o_level;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q[$];
    logic          prev_req;

    riscv_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (i_rstn),
        .o_im_addr     (o_im_addr),
        .o_im_req      (o_im_req),
        .i_im_rd       (i_im_rd),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_pc_plus4    (o_pc_plus4),
        .i_stall_d     (i_stall_d),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_level       (o_level)
    );

    // ---------------- clock / imem model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // addi x0, x0, imm with imm taken from the address, so each word names its PC.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[13:2], 5'd0, 3'b000, 5'd0, 7'h13};
    endfunction

    always @(posedge clk) begin
        i_im_rd  <= o_im_req ? imem_word(o_im_addr) : 32'hDEAD_BEEF;
        prev_req <= o_im_req;
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (i_rstn && o_instr_valid && !i_stall_d && !i_redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc %h, expected none", o_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (o_pc !== e || o_instr !== imem_word(e) || o_pc_plus4 !== e + 32'd4) begin
                    errors++;
                    $display("FAIL pop_data: got pc %h instr %h pc4 %h, expected pc %h instr %h pc4 %h",
                             o_pc, o_instr, o_pc_plus4, e, imem_word(e), e + 32'd4);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [31:0] start);
        logic [31:0] e;
        exp_q.delete();
        e = start;
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back(e);
            e = e + 32'd4;
        end
    endtask

    task automatic wait_level(input int lvl, input bit need_inflight, input string name);
        int k;
        k = 0;
        while (!((o_level == LW'(lvl)) && (!need_inflight || prev_req)) && k < 12) begin
            cyc();
            k++;
        end
        checks++;
        if (k >= 12) begin
            errors++;
            $display("FAIL %s: level %0d not reached, got %0d", name, lvl, o_level);
        end
    endtask

    task automatic wait_valid(input int exp_lat, input logic [31:0] exp_pc, input int start_k,
                              input string name);
        int k;
        k = start_k;
        while (!o_instr_valid && k < 12) begin
            cyc();
            k++;
        end
        checks++;
        if (k !== exp_lat || o_pc !== exp_pc) begin
            errors++;
            $display("FAIL %s: got latency %0d pc %h, expected latency %0d pc %h",
                     name, k, o_pc, exp_lat, exp_pc);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rstn = 1'b0; i_stall_d = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        #12;
        checks++;
        if (o_im_req !== 1'b0 || o_im_addr !== RESET_PC || o_level !== '0) begin
            errors++;
            $display("FAIL reset_fetch: got req %b addr %h level %0d, expected 0 %h 0",
                     o_im_req, o_im_addr, o_level, RESET_PC);
        end
        checks++;
        if (o_instr_valid !== 1'b0 || o_instr !== NOP || o_pc !== 32'd0 || o_pc_plus4 !== 32'd4) begin
            errors++;
            $display("FAIL reset_out: got v %b instr %h pc %h pc4 %h, expected 0 %h 0 4",
                     o_instr_valid, o_instr, o_pc, o_pc_plus4, NOP);
        end
        load_exp(RESET_PC);
        cyc();
        i_rstn = 1'b1;
        #1;
        checks++;
        if (o_im_req !== 1'b1 || o_im_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_req: got req %b addr %h, expected 1 %h", o_im_req, o_im_addr, RESET_PC);
        end
        wait_valid(LAT, RESET_PC, 0, "first_valid");
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (o_instr_valid !== 1'b1 || o_im_req !== 1'b1) begin
                errors++;
                $display("FAIL stream_gap: cycle %0d got valid %b req %b, expected 1 1",
                         i, o_instr_valid, o_im_req);
            end
        end
    endtask

    task automatic test_stall();
        i_stall_d = 1'b1;
        repeat (8) cyc();
        checks++;
        if (o_level !== LW'(DEPTH) || o_im_req !== 1'b0 || o_instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: got level %0d req %b valid %b, expected %0d 0 1",
                     o_level, o_im_req, o_instr_valid, DEPTH);
        end
        i_stall_d = 1'b0;
        repeat (12) cyc();
    endtask

    task automatic test_redirect_full();
        logic [31:0] pc_before;
        i_stall_d = 1'b1;
        wait_level(DEPTH - 1, 1'b1, "redir_setup");
        pc_before = o_pc;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0102;
        load_exp(32'h0000_0100);
        cyc();
        i_redirect = 1'b0;
        i_stall_d = 1'b0;
        checks++;
        if (o_level !== '0 || o_im_addr !== 32'h100 || o_im_req !== 1'b1) begin
            errors++;
            $display("FAIL redir_flush: got level %0d addr %h req %b, expected 0 00000100 1",
                     o_level, o_im_addr, o_im_req);
        end
        checks++;
        if (o_instr_valid !== 1'b0 || o_instr !== NOP || o_pc !== pc_before) begin
            errors++;
            $display("FAIL redir_empty_out: got v %b instr %h pc %h, expected 0 %h %h",
                     o_instr_valid, o_instr, o_pc, NOP, pc_before);
        end
        wait_valid(LAT + 1, 32'h0000_0100, 1, "redir_latency");
        repeat (8) cyc();
    endtask

    task automatic test_redirect_stall();
        i_stall_d = 1'b1;
        wait_level(2, 1'b0, "rs_setup");
        i_redirect = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        load_exp(32'h0000_0200);
        cyc();
        i_redirect = 1'b0;
        checks++;
        if (o_level !== '0 || o_im_addr !== 32'h200 || o_im_req !== 1'b1 || o_instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_over_stall: got level %0d addr %h req %b v %b, expected 0 00000200 1 0",
                     o_level, o_im_addr, o_im_req, o_instr_valid);
        end
        cyc();
        i_stall_d = 1'b0;
        repeat (10) cyc();
    endtask

    task automatic test_wrap();
        int k;
        i_redirect = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF9;
        load_exp(32'hFFFF_FFF8);
        cyc();
        i_redirect = 1'b0;
        k = 0;
        while (!(o_instr_valid && o_pc == 32'hFFFF_FFFC) && k < 12) begin
            cyc();
            k++;
        end
        checks++;
        if (k >= 12 || o_pc_plus4 !== 32'd0) begin
            errors++;
            $display("FAIL pc_wrap: got pc %h pc4 %h, expected FFFFFFFC 00000000", o_pc, o_pc_plus4);
        end
        repeat (6) cyc();
    endtask

    task automatic test_reset_midop();
        i_stall_d = 1'b1;
        wait_level(3, 1'b0, "rst_setup");
        #3;
        i_rstn = 1'b0;
        #1;
        checks++;
        if (o_instr_valid !== 1'b0 || o_instr !== NOP || o_level !== '0 || o_im_req !== 1'b0 ||
            o_pc !== 32'd0 || o_im_addr !== RESET_PC) begin
            errors++;
            $display("FAIL async_reset: got v %b instr %h level %0d req %b pc %h addr %h",
                     o_instr_valid, o_instr, o_level, o_im_req, o_pc, o_im_addr);
        end
        i_stall_d = 1'b0;
        load_exp(RESET_PC);
        cyc();
        cyc();
        i_rstn = 1'b1;
        #1;
        checks++;
        if (o_im_req !== 1'b1 || o_im_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_restart: got req %b addr %h, expected 1 %h", o_im_req, o_im_addr, RESET_PC);
        end
        wait_valid(LAT, RESET_PC, 0, "restart_valid");
        repeat (6) cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt;
        for (int i = 0; i < 80; i++) begin
            i_stall_d = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) begin
                tgt = 32'h0000_1000 + ($urandom_range(0, 255) << 2);
                i_redirect = 1'b1;
                i_redirect_pc = tgt | 32'($urandom_range(0, 3));
                load_exp(tgt);
            end
            cyc();
            i_redirect = 1'b0;
            checks++;
            if (o_level > LW'(DEPTH)) begin
                errors++;
                $display("FAIL level_bound: got %0d, expected <= %0d", o_level, DEPTH);
            end
        end
        i_stall_d = 1'b0;
        repeat (8) cyc();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_full();
        test_redirect_stall();
        test_wrap();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
